// File: rtl/sram_ctrl.sv
// Sequences 32-bit LSU accesses onto a 256Kx16 asynchronous SRAM as two halfword phases.
// Optional macro SRAM_WAIT_STATE_EN stretches every strobe (STB) state to two cycles.
module sram_ctrl #(
  parameter int ADDR_W = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_addr,
  input  logic [3:0]        i_bmask,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO_SET = 3'd1,
    LO_STB = 3'd2,
    HI_SET = 3'd3,
    HI_STB = 3'd4,
    ACK    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-2:0]   word_q, word_d;
  logic                we_q, we_d;
  logic [3:0]          bmask_q, bmask_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ce_n_q, ce_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ub_n_q, ub_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_out_q, dq_out_d;

  logic                accept;
  logic                stb_last;
  logic                pin_active;
  logic                pin_hi;
  logic                pin_stb;

  // Word alignment makes the two byte-offset bits meaningless.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[1:0];

`ifdef SRAM_WAIT_STATE_EN
  logic wait_q, wait_d;

  always_comb begin
    wait_d = 1'b0;
    if (state_q == LO_STB || state_q == HI_STB) begin
      wait_d = ~wait_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign stb_last = wait_q;
`else
  assign stb_last = 1'b1;
`endif

  assign accept = (state_q == IDLE) && i_req;

  always_comb begin
    state_d = state_q;
    word_d  = accept ? i_addr[ADDR_W:2] : word_q;
    we_d    = accept ? i_we             : we_q;
    bmask_d = accept ? i_bmask          : bmask_q;
    wdata_d = accept ? i_wdata          : wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req) begin
          if (!i_we || i_bmask[1:0] != 2'b00) begin
            state_d = LO_SET;
          end else if (i_bmask[3:2] != 2'b00) begin
            state_d = HI_SET;
          end else begin
            state_d = ACK;
          end
        end
      end
      LO_SET: state_d = LO_STB;
      LO_STB: begin
        if (stb_last) begin
          if (!we_q) begin
            rdata_d[15:0] = io_sram_dq;
          end
          state_d = (!we_q || bmask_q[3:2] != 2'b00) ? HI_SET : ACK;
        end
      end
      HI_SET: state_d = HI_STB;
      HI_STB: begin
        if (stb_last) begin
          if (!we_q) begin
            rdata_d[31:16] = io_sram_dq;
          end
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered, so they are decoded from the state being entered.
  always_comb begin
    pin_active = (state_d == LO_SET) || (state_d == LO_STB) ||
                 (state_d == HI_SET) || (state_d == HI_STB);
    pin_hi     = (state_d == HI_SET) || (state_d == HI_STB);
    pin_stb    = (state_d == LO_STB) || (state_d == HI_STB);

    addr_d   = addr_q;
    ce_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;

    if (pin_active) begin
      ce_n_d = 1'b0;
      addr_d = {word_d, pin_hi};
      if (we_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = pin_hi ? wdata_d[31:16] : wdata_d[15:0];
        we_n_d   = ~pin_stb;
        lb_n_d   = ~(pin_hi ? bmask_d[2] : bmask_d[0]);
        ub_n_d   = ~(pin_hi ? bmask_d[3] : bmask_d[1]);
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      we_q     <= 1'b0;
      bmask_q  <= 4'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      addr_q   <= '0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      we_q     <= we_d;
      bmask_q  <= bmask_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign io_sram_dq  = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
  assign o_rdata     = rdata_q;
  assign o_ack       = (state_q == ACK);
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM pin model, byte-level reference memory, vector table,
// corner-case sequences (back-to-back, reset mid-write) and randomized accesses.
module tb_sram_ctrl;
  localparam int ADDR_W = 18;
`ifdef SRAM_WAIT_STATE_EN
  localparam int STB_CYC = 2;
`else
  localparam int STB_CYC = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic              we;
  logic [ADDR_W:0]   addr;
  logic [3:0]        bmask;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              busy;
  logic [ADDR_W-1:0] sram_addr;
  wire  [15:0]       sram_dq;
  logic              ce_n, we_n, oe_n, lb_n, ub_n;

  sram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_bmask(bmask), .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack), .o_busy(busy),
    .o_sram_addr(sram_addr), .io_sram_dq(sram_dq), .o_sram_ce_n(ce_n),
    .o_sram_we_n(we_n), .o_sram_oe_n(oe_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: drives data while read-enabled, stores lanes while WE_n is low.
  logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram_mem[sram_addr][7:0]  <= sram_dq[7:0];
      if (!ub_n) sram_mem[sram_addr][15:8] <= sram_dq[15:8];
    end
  end

  // Reference model: byte-addressed memory, unwritten bytes read as zero.
  logic [7:0] ref_mem [int];
  logic [31:0] last_read_exp;

  function automatic logic [31:0] ref_read(input logic [ADDR_W:0] a);
    logic [31:0] w;
    int base;
    base = int'(a[ADDR_W:2]) * 4;
    for (int n = 0; n < 4; n++) begin
      w[8*n +: 8] = ref_mem.exists(base + n) ? ref_mem[base + n] : 8'h00;
    end
    return w;
  endfunction

  task automatic ref_write(input logic [ADDR_W:0] a, input logic [3:0] m, input logic [31:0] d);
    int base;
    base = int'(a[ADDR_W:2]) * 4;
    for (int n = 0; n < 4; n++) begin
      if (m[n]) ref_mem[base + n] = d[8*n +: 8];
    end
  endtask

  function automatic int exp_latency(input logic w, input logic [3:0] m);
    int halves;
    halves = w ? (int'(|m[1:0]) + int'(|m[3:2])) : 2;
    return 1 + halves * (1 + STB_CYC);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic              ce, we, oe, lb, ub;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dq;
    logic              is_ack;
  } pins_t;

  pins_t trace[$];

  function automatic pins_t sample_pins();
    pins_t p;
    p.ce = ce_n; p.we = we_n; p.oe = oe_n; p.lb = lb_n; p.ub = ub_n;
    p.addr = sram_addr; p.dq = sram_dq; p.is_ack = ack;
    return p;
  endfunction

  // Expected per-cycle pin sequence, built from the phase rules rather than FSM states.
  task automatic check_trace(input string name, input logic w, input logic [ADDR_W:0] a,
                             input logic [3:0] m, input logic [31:0] d);
    pins_t exp_q[$];
    pins_t e;
    logic [1:0] lanes;
    int bad;
    int first_bad;
    for (int p = 0; p < 2; p++) begin
      lanes = (p == 1) ? m[3:2] : m[1:0];
      if (!(w && lanes == 2'b00)) begin
        for (int c = 0; c <= STB_CYC; c++) begin
          e.ce = 1'b0;
          e.oe = w ? 1'b1 : 1'b0;
          e.we = (w && c > 0) ? 1'b0 : 1'b1;
          e.lb = w ? ~lanes[0] : 1'b0;
          e.ub = w ? ~lanes[1] : 1'b0;
          e.addr = {a[ADDR_W:2], (p == 1)};
          e.dq = (p == 1) ? d[31:16] : d[15:0];
          e.is_ack = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
    e = '{ce: 1'b1, we: 1'b1, oe: 1'b1, lb: 1'b1, ub: 1'b1, addr: '0, dq: '0, is_ack: 1'b1};
    exp_q.push_back(e);
    bad = (trace.size() != exp_q.size()) ? 1 : 0;
    first_bad = -1;
    for (int i = 0; i < trace.size() && i < exp_q.size(); i++) begin
      if ({trace[i].ce, trace[i].we, trace[i].oe, trace[i].lb, trace[i].ub} !==
          {exp_q[i].ce, exp_q[i].we, exp_q[i].oe, exp_q[i].lb, exp_q[i].ub} ||
          (!exp_q[i].is_ack && trace[i].addr !== exp_q[i].addr) ||
          (!exp_q[i].is_ack && w && trace[i].dq !== exp_q[i].dq)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check($sformatf("%s pins@cycle%0d", name, first_bad), bad, 0);
  endtask

  // Issue one request and record pins every cycle until the ack (bounded).
  task automatic run_txn(input logic w, input logic [ADDR_W:0] a, input logic [3:0] m,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic busy_k1);
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    req = 1'b1; we = w; addr = a; bmask = m; wdata = d;
    trace.delete();
    lat = 0; rd = 'x; busy_k1 = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0;
        busy_k1 = busy;
      end
      trace.push_back(sample_pins());
      if (ack) begin
        lat = k;
        rd = rdata;
        break;
      end
    end
  endtask

  task automatic do_check(input string name, input logic w, input logic [ADDR_W:0] a,
                          input logic [3:0] m, input logic [31:0] d, input logic [31:0] exp_rd);
    int lat;
    logic [31:0] rd;
    logic bk1;
    run_txn(w, a, m, d, lat, rd, bk1);
    $display("txn %s we=%0d addr=%05h mask=%h wdata=%08h lat=%0d rdata=%08h",
             name, w, a, m, d, lat, rd);
    check({name, " busy"}, bk1, 1'b1);
    check({name, " latency"}, lat, exp_latency(w, m));
    check({name, " rdata"}, rd, exp_rd);
    check_trace(name, w, a, m, d);
    if (w) ref_write(a, m, d);
    else last_read_exp = exp_rd;
  endtask

  typedef struct {
    logic            we;
    logic [ADDR_W:0] addr;
    logic [3:0]      bmask;
    logic [31:0]     wdata;
    logic [31:0]     exp_rdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int ack_t[3];
    int acks;
    logic [ADDR_W:0] ra;
    logic [31:0] exp_rd;
    logic        rw;
    logic [3:0]  rm;
    logic [31:0] rdat;

    for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] <= 16'h0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; bmask = '0; wdata = '0;
    last_read_exp = 32'h0;

    #12;
    check("reset strobes", {ce_n, we_n, oe_n, lb_n, ub_n}, 5'b11111);
    check("reset sram_addr", sram_addr, 0);
    check("reset ack", ack, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = '{1'b1, 19'h00010, 4'hF, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b0, 19'h00010, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 19'h00020, 4'hF, 32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 19'h00020, 4'h4, 32'h11223344, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 19'h00020, 4'h0, 32'h0,        32'hFF22FFFF};
    vecs[5]  = '{1'b1, 19'h00010, 4'h0, 32'h12345678, 32'hFF22FFFF};
    vecs[6]  = '{1'b0, 19'h00013, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b1, 19'h7FFFC, 4'h3, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 19'h7FFFC, 4'h8, 32'hA5B6C7D8, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 19'h7FFFC, 4'h0, 32'h0,        32'hA500F00D};
    vecs[10] = '{1'b0, 19'h00000, 4'h0, 32'h0,        32'h00000000};
    for (int i = 0; i < 11; i++) begin
      do_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].bmask,
               vecs[i].wdata, vecs[i].exp_rdata);
    end

    // Request held high: three reads, each re-accepted only after returning to idle.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 19'h00010; acks = 0;
    for (int t = 1; t <= 80 && acks < 3; t++) begin
      @(negedge clk);
      if (ack) begin
        ack_t[acks] = t;
        $display("txn b2b ack%0d cycle=%0d rdata=%08h", acks, t, rdata);
        check("b2b rdata", rdata, 32'hDEADBEEF);
        acks++;
        if (acks == 3) req = 1'b0;
      end
    end
    check("b2b ack count", acks, 3);
    if (acks == 3) begin
      check("b2b spacing 0-1", ack_t[1] - ack_t[0], 2 + 2 * (1 + STB_CYC));
      check("b2b spacing 1-2", ack_t[2] - ack_t[1], 2 + 2 * (1 + STB_CYC));
    end
    @(negedge clk);
    @(negedge clk);
    check("b2b idle after", busy, 1'b0);

    // Reset asserted during the low strobe of a write.
    req = 1'b1; we = 1'b1; addr = 19'h00100; bmask = 4'hF; wdata = 32'h0BADCAFE;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("midrst we_n low before reset", we_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    $display("txn midrst strobes=%b busy=%0d ack=%0d", {ce_n, we_n, oe_n, lb_n, ub_n}, busy, ack);
    check("midrst strobes async", {ce_n, we_n, oe_n, lb_n, ub_n}, 5'b11111);
    check("midrst busy", busy, 1'b0);
    check("midrst rdata", rdata, 32'h0);
    acks = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("midrst no ack", acks, 0);
    ref_write(19'h00100, 4'h3, 32'h0BADCAFE);
    last_read_exp = 32'h0;
    do_check("midrst readback", 1'b0, 19'h00100, 4'h0, 32'h0, ref_read(19'h00100));

    // Randomized traffic over a small window so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 19'h00200 + 19'($urandom_range(0, 7) * 4) + 19'($urandom_range(0, 3));
      rm = 4'($urandom_range(0, 15));
      rdat = $urandom;
      exp_rd = rw ? last_read_exp : ref_read(ra);
      do_check($sformatf("rnd%0d", i), rw, ra, rm, rdat, exp_rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
